// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and run control ahead of the instruction ROM
// Tracks IDLE/RUN/DONE, steps or redirects pc, and counts cycles spent in RUN.
module fetch_sequencer #(
  parameter int PC_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_address,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      cycle_count <= cnt_next;
      done        <= (state_next == DONE);
    end
  end

  // Counter saturates so long-running programs report all-ones rather than wrapping.
  assign cnt_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cycle_count;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = start_address;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (start) begin
          pc_next  = start_address;
          cnt_next = '0;
        end else if (halt) begin
          state_next = DONE;
          cnt_next   = cnt_inc;
        end else if (stall) begin
          cnt_next = cnt_inc;
        end else if (branch_en) begin
          pc_next  = branch_target;
          cnt_next = cnt_inc;
        end else begin
          pc_next  = pc + PC_W'(1);
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    fetch_en = (state == RUN);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and run-control stage sitting directly upstream of the instruction ROM inside top.
- Converts the top-level start / start_address handshake into a per-cycle instruction address and fetch enable.
- Applies branch redirects and stalls from the decode/execute stage.
- Raises done when the datapath signals a halt instruction, and counts executed cycles for program performance reporting.

Parameters:
- PC_W, 7, width of the instruction address and of start_address.
- CNT_W, 16, width of the executed-cycle counter.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled run request from the testbench / host.
- start_address  input  PC_W  first instruction address, sampled when start=1.
- stall  input  1  datapath hold request; PC does not advance.
- branch_en  input  1  redirect request from execute stage.
- branch_target  input  PC_W  absolute redirect address, valid when branch_en=1.
- halt  input  1  decoded halt instruction currently in execute.
- pc  output  PC_W  registered instruction address to the instruction ROM.
- fetch_en  output  1  high while the ROM output is a live instruction.
- done  output  1  registered program-complete flag to top.done.
- cycle_count  output  CNT_W  cycles spent in RUN for the last or current program.

Behaviour:
- States: IDLE, RUN, DONE, encoded in a registered state variable.
- Reset (reset_n=0, asynchronous, effective immediately regardless of clock):
  - state=IDLE, pc=0, done=0, cycle_count=0.
  - fetch_en=0, since it is decoded from state.
- fetch_en = (state==RUN); combinational from state only. done = (state==DONE), registered.
- IDLE:
  - start=1 -> pc<=start_address, cycle_count<=0, state<=RUN.
  - Otherwise all registers hold.
- RUN: per-edge priority, highest first:
  1. start=1: restart. pc<=start_address, cycle_count<=0, remain RUN.
  2. halt=1: state<=DONE, pc holds, cycle_count<=cycle_count+1.
  3. stall=1: pc holds, cycle_count+1. A concurrent branch_en is ignored; upstream holds branch_en/branch_target until stall drops.
  4. branch_en=1: pc<=branch_target, cycle_count+1.
  5. Otherwise: pc<=pc+1, modulo 2^PC_W (127 -> 0 at default width), cycle_count+1.
- cycle_count saturates at all-ones; no wrap.
- DONE:
  - done=1, pc and cycle_count frozen; halt, stall and branch_en are ignored.
  - start=1 -> same action as from IDLE: state<=RUN, pc<=start_address, cycle_count<=0. done falls on that edge.
- start held for N cycles: pc reloads start_address on each of those edges. Execution effectively begins after start falls.
- Latency:
  - start sampled at edge k -> pc=start_address and fetch_en=1 visible after edge k.
  - halt sampled at edge k -> done=1 after edge k.
- Reset asserted mid-RUN or in DONE: everything clears at once. No start is remembered across reset.
- X-safety: start_address, branch_target and halt are only sampled under the conditions above. Values outside those conditions must not affect state.

Test Plan:
- Reset then idle: reset_n=0 for 20ns, release, start=0 for 10 cycles -> pc=0, fetch_en=0, done=0, cycle_count=0 throughout.
- Basic run: start=1 for one cycle with start_address=7'd0, no branches, halt at the cycle where pc=5.
  - pc sequence 0,1,2,3,4,5 with fetch_en=1.
  - done=1 on the following edge, cycle_count=6, pc stays 5.
- Branch and stall: start_address=7'd10; branch_en=1, branch_target=7'd3 while pc=12; stall=1 for 2 cycles at pc=4 with branch_en=1, target=7'd20.
  - pc sequence 10,11,12,3,4,4,4,20.
  - Branch takes effect only after stall drops.
- Wrap and priority: start_address=7'd126, free-run -> pc 126,127,0,1. Assert halt and branch_en together at pc=1 -> DONE, pc=1.
- Restart and saturation: run 70000 cycles with no halt (CNT_W=16) -> cycle_count holds 16'hFFFF. Pulse start with start_address=7'd40 -> pc=40, cycle_count=0 next cycle.
- Reset mid-operation: assert reset_n=0 asynchronously between edges while in RUN at pc=50 -> pc=0, fetch_en=0 before the next edge. After release, restart from start=1 works normally.
